// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory bank arbiter.
// Holds the arbiter FSM encoding, port identifiers and default bus widths.
package mem_arbiter_pkg;

    localparam int unsigned REG_WIDTH      = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 16;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } arb_state_t;

    // One-hot grant vector for a port id (bit 0 = A, bit 1 = B)
    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the port
// that did not win last time. Purely combinational.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = port_onehot(~last);
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory bank between port A (CPU) and port B (DMA),
// with bounded locked bursts and out-of-window rejection.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH      = REG_WIDTH,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned BASE       = 0,
    parameter int unsigned MAX_LOCK   = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic                  a_lock,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [WIDTH-1:0]      a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [WIDTH-1:0]      a_rdata,
    output logic                  a_err,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic                  b_lock,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [WIDTH-1:0]      b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [WIDTH-1:0]      b_rdata,
    output logic                  b_err,

    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_din,
    input  logic [WIDTH-1:0]      mem_dout
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);
    localparam int unsigned EXT_W = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LOCK);
    localparam logic [EXT_W-1:0] WIN_BASE = EXT_W'(BASE);
    localparam logic [EXT_W-1:0] WIN_SIZE = EXT_W'(DEPTH);

    arb_state_t            state;
    logic [CNT_W-1:0]      lock_cnt;
    logic                  last_owner;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic [1:0]            req_vec;
    logic [1:0]            gnt;
    logic                  granted;
    logic                  sel_b;
    logic                  sel_we;
    logic                  sel_lock;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_wdata;
    logic                  other_req;
    logic                  in_win;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  lock_release;

    // Eligible requesters: a lock owner excludes the other port entirely
    always_comb begin
        req_vec = 2'b00;
        if (!reset) begin
            unique case (state)
                ST_IDLE:   req_vec = {b_req, a_req};
                ST_LOCK_A: req_vec = {1'b0, a_req};
                ST_LOCK_B: req_vec = {b_req, 1'b0};
                default:   req_vec = 2'b00;
            endcase
        end
    end

    rr_pick2 u_pick (
        .req  (req_vec),
        .last (last_owner),
        .gnt  (gnt)
    );

    assign a_gnt     = gnt[0];
    assign b_gnt     = gnt[1];
    assign granted   = |gnt;
    assign sel_b     = gnt[1];
    assign sel_we    = sel_b ? b_we    : a_we;
    assign sel_lock  = sel_b ? b_lock  : a_lock;
    assign sel_addr  = sel_b ? b_addr  : a_addr;
    assign sel_wdata = sel_b ? b_wdata : a_wdata;
    assign other_req = sel_b ? a_req   : b_req;

    // Offset compare at ADDR_WIDTH+1 bits: addresses below BASE wrap far above DEPTH
    assign in_win = (({1'b0, sel_addr} - WIN_BASE) < WIN_SIZE);

    assign mem_we   = granted & sel_we & in_win;
    assign mem_addr = granted ? sel_addr : addr_q;
    assign mem_din  = granted ? sel_wdata : '0;

    // Count of granted cycles including this one; saturates while uncontested
    assign cnt_inc = (state == ST_IDLE)    ? CNT_W'(1) :
                     (lock_cnt == CNT_MAX) ? lock_cnt  : lock_cnt + CNT_W'(1);

    assign lock_release = !sel_lock || ((cnt_inc == CNT_MAX) && other_req);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            lock_cnt   <= '0;
            last_owner <= PORT_B;
            addr_q     <= '0;
            a_rvalid   <= 1'b0;
            a_rdata    <= '0;
            a_err      <= 1'b0;
            b_rvalid   <= 1'b0;
            b_rdata    <= '0;
            b_err      <= 1'b0;
        end else begin
            a_rvalid <= 1'b0;
            a_err    <= 1'b0;
            b_rvalid <= 1'b0;
            b_err    <= 1'b0;

            if (granted) begin
                last_owner <= sel_b;
                addr_q     <= sel_addr;
                if (sel_b) begin
                    b_rvalid <= !sel_we;
                    b_err    <= !in_win;
                    if (!sel_we) b_rdata <= in_win ? mem_dout : '1;
                end else begin
                    a_rvalid <= !sel_we;
                    a_err    <= !in_win;
                    if (!sel_we) a_rdata <= in_win ? mem_dout : '1;
                end
            end

            unique case (state)
                ST_IDLE: begin
                    if (granted && !lock_release) begin
                        state    <= sel_b ? ST_LOCK_B : ST_LOCK_A;
                        lock_cnt <= cnt_inc;
                    end
                end
                ST_LOCK_A, ST_LOCK_B: begin
                    // No grant while locked means the owner dropped its request
                    if (!granted || lock_release) begin
                        state    <= ST_IDLE;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= cnt_inc;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a behavioural
// ownership/scoreboard model, plus directed scenarios.
module tb_mem_arbiter;

    localparam int WIDTH    = 8;
    localparam int AW       = 16;
    localparam int DEPTH    = 16;
    localparam int BASE     = 0;
    localparam int MAX_LOCK = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_we, a_lock, a_gnt, a_rvalid, a_err;
    logic [AW-1:0] a_addr;
    logic [7:0]    a_wdata, a_rdata;
    logic          b_req, b_we, b_lock, b_gnt, b_rvalid, b_err;
    logic [AW-1:0] b_addr;
    logic [7:0]    b_wdata, b_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din, mem_dout;

    always #5 clk = ~clk;

    mem_arbiter #(
        .WIDTH(WIDTH), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .BASE(BASE), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 29 + 7);
    endfunction

    // Attached bank: combinational read, write at posedge
    logic [7:0] bank [DEPTH];
    logic       bank_ready = 1'b0;
    always @(posedge clk) begin
        if (!bank_ready) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= init_val(i);
            bank_ready <= 1'b1;
        end else if (mem_we) begin
            bank[4'(mem_addr - 16'(BASE))] <= mem_din;
        end
    end
    assign mem_dout = bank[4'(mem_addr - 16'(BASE))];

    // Reference model state
    logic [7:0]    ref_mem [DEPTH];
    int            lock_to;
    int            run_len;
    int            last_p;
    logic [AW-1:0] last_addr;
    logic          e_rv  [2];
    logic          e_err [2];
    logic [7:0]    e_rd  [2];
    int            prev_g;
    int            n_tests;
    int            n_fail;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        lock_to   = -1;
        run_len   = 0;
        last_p    = 1;
        last_addr = '0;
        for (int p = 0; p < 2; p++) begin
            e_rv[p]  = 1'b0;
            e_err[p] = 1'b0;
            e_rd[p]  = 8'h00;
        end
    endtask

    // One clock: drive at negedge, check, then advance the model past the posedge
    task automatic step(input logic rst, input logic [1:0] rq, input logic [1:0] wr,
                        input logic [1:0] lk, input logic [AW-1:0] ad0, input logic [AW-1:0] ad1,
                        input logic [7:0] wd0, input logic [7:0] wd1);
        int            g;
        int            ia;
        bit            win;
        logic [AW-1:0] ad [2];
        logic [7:0]    wd [2];
        ad[0] = ad0; ad[1] = ad1; wd[0] = wd0; wd[1] = wd1;

        @(negedge clk);
        reset = rst;
        a_req = rq[0]; a_we = wr[0]; a_lock = lk[0]; a_addr = ad0; a_wdata = wd0;
        b_req = rq[1]; b_we = wr[1]; b_lock = lk[1]; b_addr = ad1; b_wdata = wd1;
        #1;

        check_val("a_rvalid", 32'(a_rvalid), 32'(e_rv[0]));
        check_val("b_rvalid", 32'(b_rvalid), 32'(e_rv[1]));
        check_val("a_err",    32'(a_err),    32'(e_err[0]));
        check_val("b_err",    32'(b_err),    32'(e_err[1]));
        check_val("a_rdata",  32'(a_rdata),  32'(e_rd[0]));
        check_val("b_rdata",  32'(b_rdata),  32'(e_rd[1]));

        if (rst)                          g = -1;
        else if (lock_to >= 0)            g = rq[lock_to] ? lock_to : -1;
        else if (rq[0] && rq[1])          g = 1 - last_p;
        else if (rq[0])                   g = 0;
        else if (rq[1])                   g = 1;
        else                              g = -1;

        win = 1'b0;
        if (g >= 0) begin
            ia  = int'(ad[g]);
            win = (ia >= BASE) && (ia < BASE + DEPTH);
        end

        check_val("a_gnt",  32'(a_gnt),  32'(g == 0));
        check_val("b_gnt",  32'(b_gnt),  32'(g == 1));
        check_val("mem_we", 32'(mem_we), 32'((g >= 0) && wr[g] && win));
        check_val("mem_addr", 32'(mem_addr), 32'((g >= 0) ? ad[g] : last_addr));
        if ((g >= 0) && wr[g] && win) check_val("mem_din", 32'(mem_din), 32'(wd[g]));
        prev_g = g;

        if (rst) begin
            model_reset();
        end else begin
            e_rv[0] = 1'b0; e_rv[1] = 1'b0; e_err[0] = 1'b0; e_err[1] = 1'b0;
            if ((lock_to >= 0) && !rq[lock_to]) lock_to = -1;
            if (g >= 0) begin
                last_p    = g;
                last_addr = ad[g];
                e_err[g]  = !win;
                if (!wr[g]) begin
                    e_rv[g] = 1'b1;
                    e_rd[g] = win ? ref_mem[int'(ad[g]) - BASE] : 8'hFF;
                end else if (win) begin
                    ref_mem[int'(ad[g]) - BASE] = wd[g];
                end
                if (lock_to < 0) begin
                    if (lk[g]) begin
                        lock_to = g;
                        run_len = 1;
                    end
                end else if (run_len < MAX_LOCK) begin
                    run_len++;
                end
                if ((lock_to == g) && (!lk[g] || ((run_len == MAX_LOCK) && rq[1 - g])))
                    lock_to = -1;
            end
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 8)       return AW'($urandom_range(0, 15));
        else if (r == 8) return 16'hFFFF - AW'($urandom_range(0, 2));
        else             return AW'($urandom_range(16, 65535));
    endfunction

    initial begin
        int         b_cnt;
        int         a_pos;
        bit         a_done;
        logic [5:0] pattern;
        logic [1:0] rq, wr, lk;

        n_tests = 0;
        n_fail  = 0;
        prev_g  = -1;
        reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = '0; b_wdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        model_reset();

        // Reset held with both ports requesting
        step(1'b1, 2'b11, 2'b00, 2'b00, 16'h0001, 16'h0002, 8'h00, 8'h00);
        step(1'b1, 2'b11, 2'b00, 2'b00, 16'h0001, 16'h0002, 8'h00, 8'h00);
        check_val("rst_mem_we", 32'(mem_we), 32'd0);
        step(1'b0, 2'b11, 2'b00, 2'b00, 16'h0001, 16'h0002, 8'h00, 8'h00);
        check_val("first_gnt_a", 32'(a_gnt), 32'd1);
        step(1'b0, 2'b10, 2'b00, 2'b00, 16'h0001, 16'h0002, 8'h00, 8'h00);

        // A write then read back
        step(1'b0, 2'b01, 2'b01, 2'b00, 16'h0005, 16'h0000, 8'h3C, 8'h00);
        check_val("wr_mem_we", 32'(mem_we), 32'd1);
        step(1'b0, 2'b01, 2'b00, 2'b00, 16'h0005, 16'h0000, 8'h00, 8'h00);
        check_val("rd_mem_we", 32'(mem_we), 32'd0);
        step(1'b1 & 1'b0, 2'b00, 2'b00, 2'b00, 16'h0005, 16'h0000, 8'h00, 8'h00);
        check_val("rd_a_rvalid", 32'(a_rvalid), 32'd1);
        check_val("rd_a_rdata",  32'(a_rdata),  32'h3C);

        // Make B the last owner, then contend unlocked for 6 cycles
        step(1'b0, 2'b10, 2'b10, 2'b00, 16'h0000, 16'h0009, 8'h00, 8'h5A);
        pattern = '0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 2'b11, 2'b00, 2'b00, AW'(i), AW'(i + 8), 8'h00, 8'h00);
            pattern[i] = b_gnt;
        end
        check_val("alt_pattern", 32'(pattern), 32'h2A);

        // B locked burst of 12 while A keeps requesting
        b_cnt = 0; a_pos = -1; a_done = 1'b0;
        step(1'b0, 2'b10, 2'b00, 2'b10, 16'h0003, 16'h0004, 8'h00, 8'h00);
        if (b_gnt) b_cnt++;
        for (int i = 0; i < 40 && !(a_done && b_cnt >= 12); i++) begin
            step(1'b0, {b_cnt < 12, !a_done}, 2'b00, 2'b10, 16'h0003, AW'(b_cnt), 8'h00, 8'h00);
            if (a_gnt && !a_done) begin
                a_done = 1'b1;
                a_pos  = b_cnt;
            end
            if (b_gnt) b_cnt++;
        end
        check_val("burst_a_pos", 32'(a_pos), 32'd8);
        check_val("burst_b_total", 32'(b_cnt), 32'd12);
        step(1'b0, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00);

        // Out-of-window read and write
        step(1'b0, 2'b01, 2'b00, 2'b00, 16'h0020, 16'h0000, 8'h00, 8'h00);
        check_val("oow_mem_we", 32'(mem_we), 32'd0);
        step(1'b0, 2'b10, 2'b10, 2'b00, 16'h0000, 16'hFFFF, 8'h00, 8'hAA);
        check_val("oow_a_err",    32'(a_err),    32'd1);
        check_val("oow_a_rdata",  32'(a_rdata),  32'hFF);
        check_val("oow_wr_mem_we", 32'(mem_we),  32'd0);
        step(1'b0, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00);
        check_val("oow_b_err",    32'(b_err),    32'd1);
        check_val("oow_b_rvalid", 32'(b_rvalid), 32'd0);

        // Reset while B owns a lock with a read in flight
        step(1'b0, 2'b10, 2'b00, 2'b10, 16'h0000, 16'h0002, 8'h00, 8'h00);
        step(1'b0, 2'b10, 2'b00, 2'b10, 16'h0000, 16'h0003, 8'h00, 8'h00);
        step(1'b1, 2'b10, 2'b00, 2'b10, 16'h0000, 16'h0004, 8'h00, 8'h00);
        step(1'b0, 2'b11, 2'b00, 2'b10, 16'h0001, 16'h0004, 8'h00, 8'h00);
        check_val("post_rst_b_rvalid", 32'(b_rvalid), 32'd0);
        check_val("post_rst_a_gnt",    32'(a_gnt),    32'd1);

        // Randomized traffic honouring hold-until-grant
        for (int n = 0; n < 3000; n++) begin
            rq[0] = (a_req && prev_g != 0) ? 1'b1 : ($urandom_range(0, 99) < 60);
            rq[1] = (b_req && prev_g != 1) ? 1'b1 : ($urandom_range(0, 99) < 60);
            wr = 2'($urandom_range(0, 3));
            lk = {($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 55)};
            step(($urandom_range(0, 299) == 0), rq, wr, lk, rand_addr(), rand_addr(),
                 8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
